// File: rtl/warp_fetch_pkg.sv
// Shared types for the warp fetch stage: tuple, tag-table entry and I-cache
// request/response structs. Widths follow the default core configuration.
package warp_fetch_pkg;

  localparam int unsigned NUM_WARPS_DEF   = 4;
  localparam int unsigned NUM_THREADS_DEF = 4;
  localparam int unsigned XLEN_DEF        = 32;
  localparam int unsigned UUID_WIDTH_DEF  = 44;
  localparam int unsigned NW_WIDTH        = (NUM_WARPS_DEF > 1) ? $clog2(NUM_WARPS_DEF) : 1;

  typedef logic [NW_WIDTH-1:0]        wid_t;
  typedef logic [NUM_THREADS_DEF-1:0] tmask_t;
  typedef logic [XLEN_DEF-1:0]        pc_t;
  typedef logic [XLEN_DEF-3:0]        waddr_t;
  typedef logic [UUID_WIDTH_DEF-1:0]  uuid_t;
  typedef logic [31:0]                instr_t;

  // Joined tuple handed to decode.
  typedef struct packed {
    wid_t   wid;
    tmask_t tmask;
    pc_t    pc;
    uuid_t  uuid;
    instr_t instr;
  } fetch_data_t;

  // Per-warp parked tuple waiting for its I-cache response.
  typedef struct packed {
    tmask_t tmask;
    pc_t    pc;
    uuid_t  uuid;
  } tag_entry_t;

  typedef struct packed {
    waddr_t addr;
    wid_t   tag;
  } icache_req_t;

  typedef struct packed {
    instr_t data;
    wid_t   tag;
  } icache_rsp_t;

  // Byte PC to I-cache word address.
  function automatic waddr_t word_addr(input pc_t pc);
    return pc[XLEN_DEF-1:2];
  endfunction

endpackage

// File: rtl/warp_fetch_if.sv
// Bundle of the scheduler, I-cache and decode handshakes around warp_fetch.
// The slave modport is the fetch stage's view; master is its environment.
interface warp_fetch_if;
  import warp_fetch_pkg::*;

  logic   sched_valid;
  logic   sched_ready;
  wid_t   sched_wid;
  tmask_t sched_tmask;
  pc_t    sched_pc;
  uuid_t  sched_uuid;

  logic   icache_req_valid;
  logic   icache_req_ready;
  waddr_t icache_req_addr;
  wid_t   icache_req_tag;

  logic   icache_rsp_valid;
  logic   icache_rsp_ready;
  instr_t icache_rsp_data;
  wid_t   icache_rsp_tag;

  logic   fetch_valid;
  logic   fetch_ready;
  wid_t   fetch_wid;
  tmask_t fetch_tmask;
  pc_t    fetch_pc;
  uuid_t  fetch_uuid;
  instr_t fetch_instr;

  modport slave (
    input  sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid,
    output sched_ready,
    output icache_req_valid, icache_req_addr, icache_req_tag,
    input  icache_req_ready,
    input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
    output icache_rsp_ready,
    output fetch_valid, fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr,
    input  fetch_ready
  );

  modport master (
    output sched_valid, sched_wid, sched_tmask, sched_pc, sched_uuid,
    input  sched_ready,
    input  icache_req_valid, icache_req_addr, icache_req_tag,
    output icache_req_ready,
    output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
    input  icache_rsp_ready,
    input  fetch_valid, fetch_wid, fetch_tmask, fetch_pc, fetch_uuid, fetch_instr,
    output fetch_ready
  );

endinterface

// File: rtl/warp_fetch_elastic_skid2.sv
// Two-entry valid/ready skid buffer. in_ready comes straight from a flop,
// so no combinational ready path crosses the buffer.
module elastic_skid2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             load_main;

  // Main register may take new data when empty or being drained.
  assign load_main = !main_valid || out_ready;
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Occupancy flags; skid can only be full while main is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_main) begin
      if (skid_valid) skid_valid <= 1'b0;
      else            main_valid <= in_valid;
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload registers; contents are irrelevant while the matching flag is low.
  always_ff @(posedge clk) begin
    if (load_main) begin
      main_data <= skid_valid ? skid_data : in_data;
    end else if (in_valid && !skid_valid) begin
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/warp_fetch.sv
// Instruction fetch stage: issues one I-cache read per scheduled warp tuple,
// parks the tuple per warp, and joins it with the response for decode.
// The width parameters must agree with warp_fetch_pkg; MAX_PENDING is free.
module warp_fetch
  import warp_fetch_pkg::*;
#(
  parameter int unsigned NUM_WARPS   = NUM_WARPS_DEF,
  parameter int unsigned NUM_THREADS = NUM_THREADS_DEF,
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned UUID_WIDTH  = UUID_WIDTH_DEF,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  warp_fetch_if.slave  bus,
  output logic         busy
);

  localparam int unsigned CW = $clog2(MAX_PENDING + 1);

  logic [NUM_WARPS-1:0] pending;
  logic [NUM_WARPS-1:0] pending_next;
  logic [CW-1:0]        credits;
  logic [CW-1:0]        credits_next;
  tag_entry_t           tag_table [NUM_WARPS];

  logic        sched_fire;
  logic        rsp_fire;
  logic        req_buf_ready;
  icache_req_t req_in;
  icache_req_t req_out;
  logic        out_buf_ready;
  tag_entry_t  rsp_entry;
  fetch_data_t rsp_join;
  fetch_data_t fetch_out;

  assign bus.sched_ready = req_buf_ready && (credits != '0) && !pending[bus.sched_wid];
  assign sched_fire      = bus.sched_valid && bus.sched_ready;

  assign bus.icache_rsp_ready = out_buf_ready;
  assign rsp_fire             = bus.icache_rsp_valid && out_buf_ready;

  // Credit and pending bookkeeping; an allocation wins over a same-wid free.
  always_comb begin
    pending_next = pending;
    credits_next = credits;
    if (rsp_fire)   pending_next[bus.icache_rsp_tag] = 1'b0;
    if (sched_fire) pending_next[bus.sched_wid]      = 1'b1;
    if (sched_fire && !rsp_fire) begin
      credits_next = credits - CW'(1);
    end else if (rsp_fire && !sched_fire && credits != CW'(MAX_PENDING)) begin
      credits_next = credits + CW'(1);
    end
  end

  // Outstanding-fetch state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      credits <= CW'(MAX_PENDING);
    end else begin
      pending <= pending_next;
      credits <= credits_next;
    end
  end

  // Park the scheduled tuple; table contents need no reset.
  always_ff @(posedge clk) begin
    if (sched_fire) begin
      tag_table[bus.sched_wid] <= '{tmask: bus.sched_tmask, pc: bus.sched_pc, uuid: bus.sched_uuid};
    end
  end

  // Request path: word address tagged with the warp ID.
  assign req_in = '{addr: word_addr(bus.sched_pc), tag: bus.sched_wid};

  elastic_skid2 #(.WIDTH($bits(icache_req_t))) u_req_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (sched_fire),
    .in_ready  (req_buf_ready),
    .in_data   (req_in),
    .out_valid (bus.icache_req_valid),
    .out_ready (bus.icache_req_ready),
    .out_data  (req_out)
  );

  assign bus.icache_req_addr = req_out.addr;
  assign bus.icache_req_tag  = req_out.tag;

  // Response path: join the instruction word with the parked tuple.
  assign rsp_entry = tag_table[bus.icache_rsp_tag];
  assign rsp_join  = '{wid:   bus.icache_rsp_tag,
                       tmask: rsp_entry.tmask,
                       pc:    rsp_entry.pc,
                       uuid:  rsp_entry.uuid,
                       instr: bus.icache_rsp_data};

  elastic_skid2 #(.WIDTH($bits(fetch_data_t))) u_out_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rsp_fire),
    .in_ready  (out_buf_ready),
    .in_data   (rsp_join),
    .out_valid (bus.fetch_valid),
    .out_ready (bus.fetch_ready),
    .out_data  (fetch_out)
  );

  assign bus.fetch_wid   = fetch_out.wid;
  assign bus.fetch_tmask = fetch_out.tmask;
  assign bus.fetch_pc    = fetch_out.pc;
  assign bus.fetch_uuid  = fetch_out.uuid;
  assign bus.fetch_instr = fetch_out.instr;

  // A valid skid slot always implies a valid main slot, so out_valid suffices.
  assign busy = (pending != '0) || bus.icache_req_valid || bus.fetch_valid;

  // Simulation checks: credit bound, spurious responses, package agreement.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (credits <= CW'(MAX_PENDING));
      if (bus.icache_rsp_valid) assert (pending[bus.icache_rsp_tag]);
      assert ($bits(tag_entry_t) == NUM_THREADS + XLEN + UUID_WIDTH);
    end
  end

endmodule

// File: tb/tb_warp_fetch.sv
// Testbench for warp_fetch: directed scenarios with literal expectations plus
// randomized traffic, all checked against a queue-level model of the stage.
module tb_warp_fetch;

  localparam int MAXP = 4;
  localparam int NW   = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  always #5 clk = ~clk;

  warp_fetch_if bus();

  warp_fetch #(.MAX_PENDING(MAXP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  typedef struct { logic [29:0] addr; logic [1:0] wid; } rq_t;
  typedef struct { logic [1:0] wid; logic [3:0] tmask; logic [31:0] pc; logic [43:0] uuid; logic [31:0] instr; } ft_t;
  typedef struct { logic [3:0] tmask; logic [31:0] pc; logic [43:0] uuid; } te_t;

  // Model: request buffer and output buffer as queues of at most 2 entries,
  // per-warp parked tuples, pending set, and wids the I-cache owes a response.
  rq_t        reqq[$];
  ft_t        outq[$];
  te_t        tbl[NW];
  bit         pend[NW];
  logic [1:0] icq[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int n_pending();
    int n = 0;
    for (int i = 0; i < NW; i++) if (pend[i]) n++;
    return n;
  endfunction

  function automatic bit exp_sched_ready();
    return (reqq.size() < 2) && (n_pending() < MAXP) && !pend[bus.sched_wid];
  endfunction

  task automatic model_reset();
    reqq.delete();
    outq.delete();
    icq.delete();
    for (int i = 0; i < NW; i++) pend[i] = 1'b0;
  endtask

  // Compare every DUT output against the model at the falling edge.
  task automatic sample();
    @(negedge clk);
    chk("sched_ready", 128'(bus.sched_ready), 128'(exp_sched_ready()));
    chk("req_valid", 128'(bus.icache_req_valid), 128'(reqq.size() != 0));
    if (reqq.size() != 0) begin
      chk("req_addr", 128'(bus.icache_req_addr), 128'(reqq[0].addr));
      chk("req_tag", 128'(bus.icache_req_tag), 128'(reqq[0].wid));
    end
    chk("rsp_ready", 128'(bus.icache_rsp_ready), 128'(outq.size() < 2));
    chk("fetch_valid", 128'(bus.fetch_valid), 128'(outq.size() != 0));
    if (outq.size() != 0) begin
      chk("fetch_wid", 128'(bus.fetch_wid), 128'(outq[0].wid));
      chk("fetch_tmask", 128'(bus.fetch_tmask), 128'(outq[0].tmask));
      chk("fetch_pc", 128'(bus.fetch_pc), 128'(outq[0].pc));
      chk("fetch_uuid", 128'(bus.fetch_uuid), 128'(outq[0].uuid));
      chk("fetch_instr", 128'(bus.fetch_instr), 128'(outq[0].instr));
    end
    chk("busy", 128'(busy), 128'(n_pending() != 0 || reqq.size() != 0 || outq.size() != 0));
  endtask

  // Apply this cycle's handshakes to the model, then move to posedge+1.
  task automatic advance();
    bit sf, rqf, rspf, of;
    logic [1:0] t;
    int idx;
    sf   = bus.sched_valid && exp_sched_ready();
    rqf  = (reqq.size() != 0) && bus.icache_req_ready;
    rspf = bus.icache_rsp_valid && (outq.size() < 2);
    of   = (outq.size() != 0) && bus.fetch_ready;
    if (of) void'(outq.pop_front());
    if (rspf) begin
      t = bus.icache_rsp_tag;
      outq.push_back('{t, tbl[t].tmask, tbl[t].pc, tbl[t].uuid, bus.icache_rsp_data});
      pend[t] = 1'b0;
      idx = -1;
      for (int k = 0; k < icq.size(); k++) if (idx < 0 && icq[k] == t) idx = k;
      if (idx >= 0) icq.delete(idx);
    end
    if (rqf) begin
      icq.push_back(reqq[0].wid);
      void'(reqq.pop_front());
    end
    if (sf) begin
      t = bus.sched_wid;
      tbl[t] = '{bus.sched_tmask, bus.sched_pc, bus.sched_uuid};
      pend[t] = 1'b1;
      reqq.push_back('{bus.sched_pc[31:2], t});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle();
    bus.sched_valid      = 1'b0;
    bus.sched_wid        = 2'd0;
    bus.sched_tmask      = 4'd0;
    bus.sched_pc         = 32'd0;
    bus.sched_uuid       = 44'd0;
    bus.icache_req_ready = 1'b1;
    bus.icache_rsp_valid = 1'b0;
    bus.icache_rsp_tag   = 2'd0;
    bus.icache_rsp_data  = 32'd0;
    bus.fetch_ready      = 1'b1;
  endtask

  task automatic sched(input logic [1:0] w, input logic [3:0] tm, input logic [31:0] pc, input logic [43:0] id);
    bus.sched_valid = 1'b1;
    bus.sched_wid   = w;
    bus.sched_tmask = tm;
    bus.sched_pc    = pc;
    bus.sched_uuid  = id;
  endtask

  task automatic rsp(input logic [1:0] w, input logic [31:0] d);
    bus.icache_rsp_valid = 1'b1;
    bus.icache_rsp_tag   = w;
    bus.icache_rsp_data  = d;
  endtask

  // Answer every request still owed by the I-cache, then let buffers empty.
  task automatic drain();
    for (int c = 0; c < 60 && (icq.size() != 0 || outq.size() != 0 || reqq.size() != 0); c++) begin
      idle();
      if (icq.size() != 0) rsp(icq[0], $urandom);
      tick();
    end
    idle();
    sample();
    chk("drained_busy", 128'(busy), 128'(0));
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_valid", 128'(bus.icache_req_valid), 128'(0));
    chk("rst_fetch_valid", 128'(bus.fetch_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    reset_n = 1'b1;

    // Single fetch with literal expectations.
    idle(); sched(2'd1, 4'b0001, 32'h8000_0000, 44'h123);
    sample(); chk("t1_sched_ready", 128'(bus.sched_ready), 128'(1)); advance();
    idle();
    sample();
    chk("t1_req_valid", 128'(bus.icache_req_valid), 128'(1));
    chk("t1_req_addr", 128'(bus.icache_req_addr), 128'(30'h2000_0000));
    chk("t1_req_tag", 128'(bus.icache_req_tag), 128'(1));
    advance();
    idle(); rsp(2'd1, 32'h0000_0013);
    sample(); chk("t1_rsp_ready", 128'(bus.icache_rsp_ready), 128'(1)); advance();
    idle();
    sample();
    chk("t1_fetch_valid", 128'(bus.fetch_valid), 128'(1));
    chk("t1_fetch_wid", 128'(bus.fetch_wid), 128'(1));
    chk("t1_fetch_tmask", 128'(bus.fetch_tmask), 128'(4'b0001));
    chk("t1_fetch_pc", 128'(bus.fetch_pc), 128'(32'h8000_0000));
    chk("t1_fetch_uuid", 128'(bus.fetch_uuid), 128'(44'h123));
    chk("t1_fetch_instr", 128'(bus.fetch_instr), 128'(32'h13));
    advance();
    idle(); sample(); chk("t1_busy_idle", 128'(busy), 128'(0)); advance();

    // Credit exhaustion, then same-wid refusal when the freeing response lands.
    for (int i = 0; i < 4; i++) begin
      idle(); sched(2'(i), 4'(i + 1), 32'h1000_0000 + 32'(i * 16), 44'(100 + i));
      sample(); chk("cr_accept", 128'(bus.sched_ready), 128'(1)); advance();
    end
    idle(); sched(2'd0, 4'hf, 32'h1000_0100, 44'h200);
    sample(); chk("cr_full_refused", 128'(bus.sched_ready), 128'(0)); advance();
    idle(); sched(2'd0, 4'hf, 32'h1000_0100, 44'h200); rsp(2'd0, 32'hAAAA_0000);
    sample(); chk("cr_race_refused", 128'(bus.sched_ready), 128'(0)); advance();
    idle(); sched(2'd0, 4'hf, 32'h1000_0100, 44'h200);
    sample(); chk("cr_credit_back", 128'(bus.sched_ready), 128'(1)); advance();
    drain();

    // Out-of-order responses 2,0,1 with a same-wid race on wid 2.
    for (int i = 0; i < 3; i++) begin
      idle(); sched(2'(i), 4'b1111, 32'h0000_4000 + 32'(i * 4), 44'(300 + i)); tick();
    end
    idle(); tick();
    idle(); rsp(2'd2, 32'hA2); sched(2'd2, 4'b0100, 32'h0000_5000, 44'h400);
    sample(); chk("race2_refused", 128'(bus.sched_ready), 128'(0)); advance();
    idle(); rsp(2'd0, 32'hA0); sched(2'd2, 4'b0100, 32'h0000_5000, 44'h400);
    sample();
    chk("race2_accepted", 128'(bus.sched_ready), 128'(1));
    chk("ooo_pc2", 128'(bus.fetch_pc), 128'(32'h0000_4008));
    chk("ooo_uuid2", 128'(bus.fetch_uuid), 128'(44'd302));
    advance();
    idle(); rsp(2'd1, 32'hA1); tick();
    idle(); sample(); chk("race2_pending_busy", 128'(busy), 128'(1)); advance();
    drain();

    // Backpressure: decode stalls for 5 cycles while 3 responses arrive.
    for (int i = 0; i < 3; i++) begin
      idle(); sched(2'(i), 4'b0011, 32'h0000_6000 + 32'(i * 4), 44'(500 + i)); tick();
    end
    idle(); tick();
    idle(); bus.fetch_ready = 1'b0; rsp(2'd0, 32'hB0);
    sample(); chk("bp_rdy0", 128'(bus.icache_rsp_ready), 128'(1)); advance();
    idle(); bus.fetch_ready = 1'b0; rsp(2'd1, 32'hB1);
    sample(); chk("bp_rdy1", 128'(bus.icache_rsp_ready), 128'(1)); advance();
    idle(); bus.fetch_ready = 1'b0; rsp(2'd2, 32'hB2);
    sample(); chk("bp_rdy2_full", 128'(bus.icache_rsp_ready), 128'(0)); advance();
    for (int k = 0; k < 10 && pend[2]; k++) begin
      idle(); bus.fetch_ready = (k >= 2); rsp(2'd2, 32'hB2); tick();
    end
    chk("bp_rsp2_taken", 128'(pend[2]), 128'(0));
    drain();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.sched_valid      = ($urandom_range(3) != 0);
      bus.sched_wid        = 2'($urandom_range(3));
      bus.sched_tmask      = 4'($urandom);
      bus.sched_pc         = $urandom;
      bus.sched_uuid       = {12'($urandom), $urandom};
      bus.icache_req_ready = ($urandom_range(3) != 0);
      if (icq.size() != 0 && $urandom_range(2) != 0) begin
        bus.icache_rsp_valid = 1'b1;
        bus.icache_rsp_tag   = icq[$urandom_range(icq.size() - 1)];
      end else begin
        bus.icache_rsp_valid = 1'b0;
        bus.icache_rsp_tag   = 2'($urandom_range(3));
      end
      bus.icache_rsp_data = $urandom;
      bus.fetch_ready     = ((c % 200) < 20) ? 1'b0 : ($urandom_range(3) != 0);
      tick();
    end
    drain();

    // Reset with three fetches in flight and both buffers occupied.
    idle(); sched(2'd0, 4'b1, 32'h0000_7000, 44'h600); tick();
    idle(); sched(2'd1, 4'b1, 32'h0000_7004, 44'h601); tick();
    idle(); sched(2'd2, 4'b1, 32'h0000_7008, 44'h602);
    bus.icache_req_ready = 1'b0; bus.fetch_ready = 1'b0; rsp(2'd0, 32'hC0); tick();
    chk("mr_req_valid_before", 128'(bus.icache_req_valid), 128'(1));
    chk("mr_fetch_valid_before", 128'(bus.fetch_valid), 128'(1));
    idle();
    reset_n = 1'b0;
    #1;
    chk("mr_req_valid_async", 128'(bus.icache_req_valid), 128'(0));
    chk("mr_fetch_valid_async", 128'(bus.fetch_valid), 128'(0));
    chk("mr_busy_async", 128'(busy), 128'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(); sample();
    chk("mr_busy_after", 128'(busy), 128'(0));
    chk("mr_ready_after", 128'(bus.sched_ready), 128'(1));
    advance();
    for (int i = 0; i < 4; i++) begin
      idle(); sched(2'(i), 4'b1000, 32'h0000_8000 + 32'(i * 4), 44'(700 + i));
      sample(); chk("mr_full_credits", 128'(bus.sched_ready), 128'(1)); advance();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
